// File: rtl/aes_mslot_pkg.sv
// aes_mslot_pkg: shared constants and types for the multi-slot AES block.
//   - global register byte offsets (CTRL, CONFIG, START, STATUS, DONE_CLR, IRQ_MASK)
//   - slot window sub-offsets (block, key, result)
//   - scheduler FSM state enum
//   - bit index of the START command
// Optional feature macro used by the block: AES_MSLOT_IRQ_MASK_EN.
package aes_mslot_pkg;

    localparam logic [31:0] CTRL_OFF     = 32'h00;
    localparam logic [31:0] CONFIG_OFF   = 32'h04;
    localparam logic [31:0] START_OFF    = 32'h08;
    localparam logic [31:0] STATUS_OFF   = 32'h0C;
    localparam logic [31:0] DONE_CLR_OFF = 32'h10;
    localparam logic [31:0] IRQ_MASK_OFF = 32'h14;

    // Slot window layout: four 32-bit words per field.
    localparam logic [31:0] SUB_BLOCK_OFF  = 32'h00;
    localparam logic [31:0] SUB_KEY_OFF    = 32'h10;
    localparam logic [31:0] SUB_RESULT_OFF = 32'h20;
    localparam logic [31:0] SLOT_SPAN      = 32'h30;

    localparam int unsigned START_BIT = 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEL,
        S_LAUNCH,
        S_WAIT
    } aes_mslot_state_e;

endpackage

// File: rtl/aes_mslot_if.sv
// aes_mslot_if: peripheral bus bundle for aes_mslot.
//   cs_i    - bus select
//   we_i    - 1 = write, 0 = read
//   addr_i  - byte address (bits [1:0] ignored)
//   wdata_i - write data
//   rdata_o - combinational read data, 0 when no read is in progress
// Handshake: a transfer occurs on every clock edge where cs_i is high; there
// is no wait state, so reads return data in the same cycle and writes take
// effect at that edge.
interface aes_mslot_if;
    logic        cs_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;

    modport master (output cs_i, we_i, addr_i, wdata_i, input rdata_o);
    modport slave  (input cs_i, we_i, addr_i, wdata_i, output rdata_o);
endinterface

// File: rtl/aes_core.sv
// aes_core: iterative AES-128 engine, one round per clock.
//   clk_i, rst_ni    - clock, asynchronous active-low reset
//   on_i             - one-cycle start pulse; key_i/block_i/encdec_i captured then
//   encdec_i         - 1 = encrypt, 0 = decrypt
//   key_i, block_i   - 128-bit key and block, byte 0 in bits [127:120]
//   result_o         - result, held until the next operation finishes
//   result_valid_o   - one-cycle pulse when result_o is updated
// Decrypt first runs the key schedule forward (10 cycles) to reach the last
// round key, then walks it backwards one round at a time.
module aes_core (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         on_i,
    input  logic         encdec_i,
    input  logic [127:0] key_i,
    input  logic [127:0] block_i,
    output logic [127:0] result_o,
    output logic         result_valid_o
);
    typedef enum logic [1:0] {C_IDLE, C_KEXP, C_ROUND} core_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Inverse of xtime, used to step the round constant backwards.
    function automatic logic [7:0] inv_xtime(input logic [7:0] b);
        return b[0] ? (((b ^ 8'h1b) >> 1) | 8'h80) : (b >> 1);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0).
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gmul(r, r);
            if (i != 0) r = gmul(r, x);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b = ginv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return ginv({y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] inv_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0] ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_rot(w3) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [127:0] o;
        for (int n = 0; n < 16; n++) b[n] = s[127-8*n -: 8];
        for (int n = 0; n < 16; n++) t[n] = sbox(b[4*(((n/4)+(n%4))%4) + (n%4)]);
        for (int c = 0; c < 4; c++) begin
            logic [7:0] a0, a1, a2, a3;
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (!last) begin
                t[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                t[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
            end
        end
        for (int n = 0; n < 16; n++) o[127-8*n -: 8] = t[n];
        return o ^ rk;
    endfunction

    function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [127:0] o;
        for (int n = 0; n < 16; n++) b[n] = s[127-8*n -: 8];
        for (int n = 0; n < 16; n++) t[n] = inv_sbox(b[4*(((n/4)-(n%4)+4)%4) + (n%4)]) ^ rk[127-8*n -: 8];
        for (int c = 0; c < 4; c++) begin
            logic [7:0] a0, a1, a2, a3;
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (!last) begin
                t[4*c]   = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
                t[4*c+1] = gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
                t[4*c+2] = gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
                t[4*c+3] = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14);
            end
        end
        for (int n = 0; n < 16; n++) o[127-8*n -: 8] = t[n];
        return o;
    endfunction

    core_state_e  cst_q, cst_d;
    logic [127:0] st_q, st_d, rk_q, rk_d, res_q, res_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         enc_q, enc_d, valid_q, valid_d;
    logic [127:0] nk, nxt;
    logic [7:0]   rcp;

    always_comb begin
        cst_d = cst_q; st_d = st_q; rk_d = rk_q; res_d = res_q;
        rcon_d = rcon_q; cnt_d = cnt_q; enc_d = enc_q; valid_d = 1'b0;
        nk = '0; nxt = '0; rcp = '0;
        case (cst_q)
            C_IDLE: begin
                if (on_i) begin
                    enc_d = encdec_i; rk_d = key_i; rcon_d = 8'h01; cnt_d = '0;
                    st_d  = encdec_i ? (block_i ^ key_i) : block_i;
                    cst_d = encdec_i ? C_ROUND : C_KEXP;
                end
            end
            C_KEXP: begin
                nk = expand(rk_q, rcon_q);
                rk_d = nk; rcon_d = xtime(rcon_q); cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    st_d = st_q ^ nk; cnt_d = '0; cst_d = C_ROUND;
                end
            end
            C_ROUND: begin
                if (enc_q) begin
                    nk = expand(rk_q, rcon_q);
                    nxt = enc_round(st_q, nk, cnt_q == 4'd9);
                    rcon_d = xtime(rcon_q);
                end else begin
                    rcp = inv_xtime(rcon_q);
                    nk = inv_expand(rk_q, rcp);
                    nxt = dec_round(st_q, nk, cnt_q == 4'd9);
                    rcon_d = rcp;
                end
                st_d = nxt; rk_d = nk; cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    res_d = nxt; valid_d = 1'b1; cst_d = C_IDLE;
                end
            end
            default: cst_d = C_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cst_q <= C_IDLE; st_q <= '0; rk_q <= '0; res_q <= '0;
            rcon_q <= '0; cnt_q <= '0; enc_q <= 1'b0; valid_q <= 1'b0;
        end else begin
            cst_q <= cst_d; st_q <= st_d; rk_q <= rk_d; res_q <= res_d;
            rcon_q <= rcon_d; cnt_q <= cnt_d; enc_q <= enc_d; valid_q <= valid_d;
        end
    end

    assign result_o       = res_q;
    assign result_valid_o = valid_q;
endmodule

// File: rtl/aes_mslot_pick.sv
// aes_mslot_pick: combinational lowest-set-bit picker.
//   vec_i - request vector (N bits)
//   idx_o - index of the lowest set bit (0 when none set)
//   any_o - 1 when any bit of vec_i is set
module aes_mslot_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  vec_i,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    always_comb begin
        idx_o = '0;
        // Scan from the top so the lowest set index is the last one written.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = IW'(i);
        end
        any_o = |vec_i;
    end
endmodule

// File: rtl/aes_mslot.sv
// aes_mslot: multi-slot AES-128 accelerator serialising NUM_SLOTS contexts
// through one shared aes_core.
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   bus           - aes_mslot_if.slave register bus (cs/we/addr/wdata/rdata)
//   irq_o         - registered level interrupt from the sticky done vector
// Macro AES_MSLOT_IRQ_MASK_EN adds the IRQ_MASK register and gates irq_o.
module aes_mslot
    import aes_mslot_pkg::*;
#(
    parameter int unsigned NUM_SLOTS   = 4,
    parameter logic [31:0] SLOT_BASE   = 32'h100,
    parameter logic [31:0] SLOT_STRIDE = 32'h40
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    aes_mslot_if.slave bus,
    output logic       irq_o
);
    localparam int unsigned IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int unsigned N  = NUM_SLOTS;

    aes_mslot_state_e state_q, state_d;
    logic [N-1:0]  on_q, on_d, cfg_q, cfg_d, done_q, done_d;
    logic [N-1:0]  pending_q, pending_d, last_set_q, last_set_d;
    logic [IW-1:0] active_q, active_d;
    logic          enc_q, enc_d, irq_q, irq_d;
    logic [127:0]  block_q [N];
    logic [127:0]  block_d [N];
    logic [127:0]  key_q [N];
    logic [127:0]  key_d [N];
    logic [127:0]  result_q [N];
    logic [127:0]  result_d [N];
`ifdef AES_MSLOT_IRQ_MASK_EN
    logic [N-1:0]  mask_q, mask_d;
`endif

    logic [31:0]   addr_w, rdata;
    logic          wr, rd, slot_hit, busy, start_wr, pick_any, core_on, core_encdec, core_valid;
    logic [IW-1:0] slot_idx, pick_idx;
    logic [3:0]    slot_word;
    logic [31:0]   rel;
    logic [127:0]  core_result;
    logic          unused_addr_lsb;

    assign addr_w = {bus.addr_i[31:2], 2'b00};
    assign unused_addr_lsb = ^bus.addr_i[1:0];
    assign wr   = bus.cs_i & bus.we_i;
    assign rd   = bus.cs_i & ~bus.we_i;
    assign busy = (state_q == S_LAUNCH) || (state_q == S_WAIT);

    // Slot window decode; unsigned wrap makes (addr - lo) < span a range test.
    always_comb begin
        slot_hit = 1'b0; slot_idx = '0; slot_word = '0; rel = '0;
        for (int s = 0; s < int'(N); s++) begin
            rel = addr_w - SLOT_BASE - SLOT_STRIDE * 32'(s);
            if (rel < SLOT_SPAN) begin
                slot_hit = 1'b1; slot_idx = IW'(s); slot_word = rel[5:2];
            end
        end
    end

    assign start_wr = wr && !slot_hit && (addr_w == START_OFF) && bus.wdata_i[START_BIT];

    aes_mslot_pick #(.N(N), .IW(IW)) u_pick (
        .vec_i (pending_q),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        state_d = state_q; on_d = on_q; cfg_d = cfg_q; done_d = done_q;
        pending_d = pending_q; last_set_d = last_set_q; active_d = active_q;
        enc_d = enc_q; block_d = block_q; key_d = key_q; result_d = result_q;
        core_on = 1'b0;
`ifdef AES_MSLOT_IRQ_MASK_EN
        mask_d = mask_q;
`endif
        if (wr && !slot_hit) begin
            case (addr_w)
                CTRL_OFF:     on_d   = bus.wdata_i[N-1:0];
                CONFIG_OFF:   cfg_d  = bus.wdata_i[N-1:0];
                DONE_CLR_OFF: done_d = done_d & ~bus.wdata_i[N-1:0];
`ifdef AES_MSLOT_IRQ_MASK_EN
                IRQ_MASK_OFF: mask_d = bus.wdata_i[N-1:0];
`endif
                default: ;
            endcase
        end
        // The slot feeding the core is frozen while it is in flight.
        if (wr && slot_hit && !(busy && slot_idx == active_q)) begin
            case (slot_word[3:2])
                2'd0: block_d[slot_idx][127 - 32*int'(slot_word[1:0]) -: 32] = bus.wdata_i;
                2'd1: key_d[slot_idx][127 - 32*int'(slot_word[1:0]) -: 32]   = bus.wdata_i;
                default: ;
            endcase
        end
        case (state_q)
            S_IDLE: begin
                if (start_wr && on_q != '0) begin
                    pending_d  = on_q;
                    last_set_d = on_q;
                    done_d     = done_d & ~on_q;
                    state_d    = S_SEL;
                end
            end
            S_SEL: begin
                if (pick_any) begin
                    active_d = pick_idx;
                    state_d  = S_LAUNCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                core_on = 1'b1;
                enc_d   = cfg_q[active_q];
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Applied after DONE_CLR so a same-cycle set wins.
                if (core_valid) begin
                    result_d[active_q]  = core_result;
                    done_d[active_q]    = 1'b1;
                    pending_d[active_q] = 1'b0;
                    state_d             = S_SEL;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef AES_MSLOT_IRQ_MASK_EN
        irq_d = |(done_q & mask_q);
`else
        irq_d = |done_q;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE; on_q <= '0; cfg_q <= '0; done_q <= '0;
            pending_q <= '0; last_set_q <= '0; active_q <= '0;
            enc_q <= 1'b0; irq_q <= 1'b0;
            for (int s = 0; s < int'(N); s++) begin
                block_q[s] <= '0; key_q[s] <= '0; result_q[s] <= '0;
            end
`ifdef AES_MSLOT_IRQ_MASK_EN
            mask_q <= '0;
`endif
        end else begin
            state_q <= state_d; on_q <= on_d; cfg_q <= cfg_d; done_q <= done_d;
            pending_q <= pending_d; last_set_q <= last_set_d; active_q <= active_d;
            enc_q <= enc_d; irq_q <= irq_d;
            for (int s = 0; s < int'(N); s++) begin
                block_q[s] <= block_d[s]; key_q[s] <= key_d[s]; result_q[s] <= result_d[s];
            end
`ifdef AES_MSLOT_IRQ_MASK_EN
            mask_q <= mask_d;
`endif
        end
    end

    // CONFIG is taken live during LAUNCH, then held for the rest of the op.
    assign core_encdec = (state_q == S_LAUNCH) ? cfg_q[active_q] : enc_q;

    aes_core u_core (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .on_i           (core_on),
        .encdec_i       (core_encdec),
        .key_i          (key_q[active_q]),
        .block_i        (block_q[active_q]),
        .result_o       (core_result),
        .result_valid_o (core_valid)
    );

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (slot_hit) begin
                case (slot_word[3:2])
                    2'd0: rdata = block_q[slot_idx][127 - 32*int'(slot_word[1:0]) -: 32];
                    2'd1: rdata = key_q[slot_idx][127 - 32*int'(slot_word[1:0]) -: 32];
                    2'd2: rdata = result_q[slot_idx][127 - 32*int'(slot_word[1:0]) -: 32];
                    default: ;
                endcase
            end else begin
                case (addr_w)
                    CTRL_OFF:   rdata[N-1:0] = on_q;
                    CONFIG_OFF: rdata[N-1:0] = cfg_q;
                    STATUS_OFF: begin
                        rdata[0]       = (state_q == S_IDLE);
                        rdata[1]       = (done_q == last_set_q) && (last_set_q != '0);
                        rdata[16 +: N] = done_q;
                    end
`ifdef AES_MSLOT_IRQ_MASK_EN
                    IRQ_MASK_OFF: rdata[N-1:0] = mask_q;
`endif
                    default: ;
                endcase
            end
        end
    end

    assign bus.rdata_o = rdata;
    assign irq_o       = irq_q;
endmodule

// File: tb/tb_aes_mslot.sv
module tb_aes_mslot;
    import aes_mslot_pkg::*;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic irq;
    int   checks = 0;
    int   errors = 0;
    int   pulse_cnt = 0;
    logic [3:0] order_q[$];

    logic [31:0] key_w [4] = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
    logic [31:0] pt_w  [4] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    logic [31:0] ct_w  [4] = '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};

    aes_mslot_if bus ();

    aes_mslot #(.NUM_SLOTS(4), .SLOT_BASE(32'h100), .SLOT_STRIDE(32'h40)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus),
        .irq_o  (irq)
    );

    always #5 clk = ~clk;

    // LAUNCH lasts one full cycle, so each core start is seen on exactly one negedge.
    always @(negedge clk) begin
        if (dut.core_on) begin
            pulse_cnt++;
            order_q.push_back(4'(dut.active_q));
        end
    end

    function automatic logic [31:0] sa(input int s, input int off);
        return 32'h100 + 32'(s) * 32'h40 + 32'(off);
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.cs_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = a; bus.wdata_i = d;
        @(negedge clk);
        bus.cs_i = 1'b0; bus.we_i = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.cs_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = a;
        #1 d = bus.rdata_o;
        bus.cs_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        logic [31:0] s;
        int n = 0;
        do begin
            rd(STATUS_OFF, s);
            n++;
        end while (!s[0] && n < 400);
        checks++;
        if (!s[0]) begin
            errors++;
            $display("FAIL %s_idle: STATUS=%h after %0d polls, required idle bit 1", name, s, n);
        end
    endtask

    task automatic wait_busy_wait(input string name);
        int n = 0;
        while (dut.state_q != S_WAIT && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dut.state_q != S_WAIT) begin
            errors++;
            $display("FAIL %s_reach_wait: state=%0d, required WAIT", name, dut.state_q);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        bus.cs_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0;
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b, required 0", irq); end
        rd(STATUS_OFF, d); checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL reset_status: got %h, required 00000001", d); end
        rd(CTRL_OFF, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h, required 0", d); end
        rd(sa(0, 32), d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_result: got %h, required 0", d); end
    endtask

    task automatic test_fips_encrypt();
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            wr(sa(0, 16 + 4*i), key_w[i]);
            wr(sa(0, 4*i), pt_w[i]);
        end
        wr(CONFIG_OFF, 32'h1);
        wr(CTRL_OFF, 32'h1);
        wr(START_OFF, 32'h1);
        wait_idle("fips");
        for (int i = 0; i < 4; i++) begin
            rd(sa(0, 32 + 4*i), d); checks++;
            if (d !== ct_w[i]) begin errors++; $display("FAIL fips_word%0d: got %h, required %h", i, d, ct_w[i]); end
        end
        rd(STATUS_OFF, d); checks++;
        if (d !== 32'h00010003) begin errors++; $display("FAIL fips_status: got %h, required 00010003", d); end
        rd(START_OFF, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL start_read: got %h, required 0", d); end
        @(negedge clk); checks++;
`ifdef AES_MSLOT_IRQ_MASK_EN
        if (irq !== 1'b0) begin errors++; $display("FAIL fips_irq: got %b, required 0 (masked)", irq); end
`else
        if (irq !== 1'b1) begin errors++; $display("FAIL fips_irq: got %b, required 1", irq); end
`endif
    endtask

    task automatic test_decrypt();
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            wr(sa(2, 16 + 4*i), key_w[i]);
            wr(sa(2, 4*i), ct_w[i]);
        end
        wr(CONFIG_OFF, 32'h1);
        wr(CTRL_OFF, 32'h4);
        wr(START_OFF, 32'h1);
        wait_idle("dec");
        for (int i = 0; i < 4; i++) begin
            rd(sa(2, 32 + 4*i), d); checks++;
            if (d !== pt_w[i]) begin errors++; $display("FAIL dec_word%0d: got %h, required %h", i, d, pt_w[i]); end
        end
        // done[0] is left over from the earlier run, so all_done is 0.
        rd(STATUS_OFF, d); checks++;
        if (d !== 32'h00050001) begin errors++; $display("FAIL dec_status: got %h, required 00050001", d); end
    endtask

    task automatic test_skip();
        logic [31:0] d;
        int p0, o0;
        wr(DONE_CLR_OFF, 32'hF);
        wr(CTRL_OFF, 32'hA);
        p0 = pulse_cnt;
        o0 = order_q.size();
        wr(START_OFF, 32'h1);
        wait_idle("skip");
        checks++;
        if (pulse_cnt - p0 !== 2) begin errors++; $display("FAIL skip_pulses: got %0d, required 2", pulse_cnt - p0); end
        checks++;
        if (order_q.size() < o0 + 2) begin
            errors++; $display("FAIL skip_order: got %0d entries, required 2", order_q.size() - o0);
        end else if (order_q[o0] !== 4'd1 || order_q[o0+1] !== 4'd3) begin
            errors++; $display("FAIL skip_order: got %0d,%0d, required 1,3", order_q[o0], order_q[o0+1]);
        end
        rd(STATUS_OFF, d); checks++;
        if (d !== 32'h000A0003) begin errors++; $display("FAIL skip_status: got %h, required 000a0003", d); end
        rd(sa(0, 32), d); checks++;
        if (d !== ct_w[0]) begin errors++; $display("FAIL skip_slot0: got %h, required %h", d, ct_w[0]); end
        rd(sa(2, 32), d); checks++;
        if (d !== pt_w[0]) begin errors++; $display("FAIL skip_slot2: got %h, required %h", d, pt_w[0]); end
        wr(sa(0, 32), 32'hFFFF0000);
        rd(sa(0, 32), d); checks++;
        if (d !== ct_w[0]) begin errors++; $display("FAIL result_ro: got %h, required %h", d, ct_w[0]); end
        rd(32'h200, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL unmapped_slot: got %h, required 0", d); end
    endtask

    task automatic test_busy_guards();
        logic [31:0] d;
        int p0;
        wr(CTRL_OFF, 32'h1);
        wr(CONFIG_OFF, 32'h1);
        p0 = pulse_cnt;
        wr(START_OFF, 32'h1);
        wait_busy_wait("busy");
        wr(START_OFF, 32'h1);
        wr(sa(0, 16), 32'hDEADBEEF);
        wr(sa(1, 16), 32'h12345678);
        wait_idle("busy");
        checks++;
        if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL busy_pulses: got %0d, required 1", pulse_cnt - p0); end
        rd(sa(0, 32), d); checks++;
        if (d !== ct_w[0]) begin errors++; $display("FAIL busy_result: got %h, required %h", d, ct_w[0]); end
        rd(sa(0, 16), d); checks++;
        if (d !== key_w[0]) begin errors++; $display("FAIL busy_active_key: got %h, required %h", d, key_w[0]); end
        rd(sa(1, 16), d); checks++;
        if (d !== 32'h12345678) begin errors++; $display("FAIL busy_idle_key: got %h, required 12345678", d); end
    endtask

    task automatic test_irq_clear();
        logic [31:0] d;
`ifdef AES_MSLOT_IRQ_MASK_EN
        logic early;
        int n;
        wr(DONE_CLR_OFF, 32'hF);
        wr(IRQ_MASK_OFF, 32'h2);
        rd(IRQ_MASK_OFF, d); checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL mask_read: got %h, required 2", d); end
        wr(CTRL_OFF, 32'h3);
        wr(START_OFF, 32'h1);
        early = 1'b0; n = 0;
        do begin
            rd(STATUS_OFF, d);
            if (irq === 1'b1 && d[17] !== 1'b1) early = 1'b1;
            n++;
        end while (!d[0] && n < 400);
        checks++;
        if (early !== 1'b0) begin errors++; $display("FAIL irq_early: got %b, required 0", early); end
        @(negedge clk); checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_after_slot1: got %b, required 1", irq); end
        wr(DONE_CLR_OFF, 32'h2);
`else
        wr(IRQ_MASK_OFF, 32'hF);
        rd(IRQ_MASK_OFF, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL mask_absent: got %h, required 0", d); end
        wr(DONE_CLR_OFF, 32'hE);
        @(negedge clk); checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_partial_clr: got %b, required 1", irq); end
        wr(DONE_CLR_OFF, 32'h1);
`endif
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_clr_lag: got %b, required 1", irq); end
        @(negedge clk); checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_clr_drop: got %b, required 0", irq); end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] d;
        int p1;
        wr(CTRL_OFF, 32'h1);
        wr(START_OFF, 32'h1);
        wait_busy_wait("rst");
        @(negedge clk); rst_ni = 1'b0;
        @(negedge clk); rst_ni = 1'b1;
        p1 = pulse_cnt;
        repeat (40) @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b, required 0", irq); end
        rd(STATUS_OFF, d); checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL rst_status: got %h, required 00000001", d); end
        for (int s = 0; s < 4; s++) begin
            for (int w = 0; w < 4; w++) begin
                rd(sa(s, 32 + 4*w), d); checks++;
                if (d !== 32'h0) begin errors++; $display("FAIL rst_result_s%0d_w%0d: got %h, required 0", s, w, d); end
            end
        end
        checks++;
        if (pulse_cnt !== p1) begin errors++; $display("FAIL rst_pulses: got %0d extra, required 0", pulse_cnt - p1); end
    endtask

    initial begin
        test_reset();
        test_fips_encrypt();
        test_decrypt();
        test_skip();
        test_busy_guards();
        test_irq_clear();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
